// File: rtl/vend_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_pkg : state encoding, coin values and price/credit defaults      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vend_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_CREDIT = 2'd1,
      S_VEND   = 2'd2,
      S_REFUND = 2'd3
   } vend_state_t;

   localparam int c_coin1_val      = 1;
   localparam int c_coin5_val      = 5;
   localparam int c_max_credit_def = 15;
   localparam int c_price_a_def    = 3;
   localparam int c_price_b_def    = 5;

endpackage
`default_nettype wire

// File: rtl/coin_vend_fsm_key_edge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | key_edge : key input register with falling-edge (press) detect       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module key_edge (
   input  logic clk,
   input  logic rst,
   input  logic i_key_n,
   output logic o_fall
);

   logic r_key_q;

   always_ff @(posedge clk) begin
      if (rst) r_key_q <= 1'b1;
      else     r_key_q <= i_key_n;
   end

   assign o_fall = r_key_q & ~i_key_n;

endmodule
`default_nettype wire

// File: rtl/coin_vend_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | coin_vend_fsm : two-product coin vending controller with refund      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module coin_vend_fsm
   import vend_pkg::*;
#(
   parameter int PRICE_A    = c_price_a_def,
   parameter int PRICE_B    = c_price_b_def,
   parameter int MAX_CREDIT = c_max_credit_def
) (
   input  logic       vend_clk,
   input  logic       vend_rst,
   input  logic       key_coin1_n,
   input  logic       key_coin5_n,
   input  logic       key_sel_a_n,
   input  logic       key_sel_b_n,
   input  logic       key_cancel_n,
   output logic [3:0] credit,
   output logic       vend_a,
   output logic       vend_b,
   output logic       change_pulse,
   output logic       coin_reject,
   output logic       no_funds,
   output logic       busy
);

   localparam logic [3:0] c_price_a = 4'(PRICE_A);
   localparam logic [3:0] c_price_b = 4'(PRICE_B);
   localparam logic [4:0] c_max     = 5'(MAX_CREDIT);

   // bit order doubles as priority: [4] cancel ... [0] coin1
   logic [4:0] w_keys_n;
   logic [4:0] w_evt;

   assign w_keys_n = {key_cancel_n, key_sel_a_n, key_sel_b_n, key_coin5_n, key_coin1_n};

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_key
         key_edge u_key_edge (
            .clk     (vend_clk),
            .rst     (vend_rst),
            .i_key_n (w_keys_n[gi]),
            .o_fall  (w_evt[gi])
         );
      end
   endgenerate

   vend_state_t r_state, w_state_nxt;
   logic [3:0]  r_credit, w_credit_nxt;
   logic        r_phase, w_phase_nxt;
   logic        r_vend_a, w_vend_a_nxt;
   logic        r_vend_b, w_vend_b_nxt;
   logic        r_change, w_change_nxt;
   logic        r_reject, w_reject_nxt;
   logic        r_no_funds, w_no_funds_nxt;
   logic        r_busy, w_busy_nxt;
   logic [3:0]  w_price;
   logic [4:0]  w_coin;
   logic [4:0]  w_sum;

   always_ff @(posedge vend_clk) begin
      if (vend_rst) begin
         r_state    <= S_IDLE;
         r_credit   <= 4'd0;
         r_phase    <= 1'b0;
         r_vend_a   <= 1'b0;
         r_vend_b   <= 1'b0;
         r_change   <= 1'b0;
         r_reject   <= 1'b0;
         r_no_funds <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_credit   <= w_credit_nxt;
         r_phase    <= w_phase_nxt;
         r_vend_a   <= w_vend_a_nxt;
         r_vend_b   <= w_vend_b_nxt;
         r_change   <= w_change_nxt;
         r_reject   <= w_reject_nxt;
         r_no_funds <= w_no_funds_nxt;
         r_busy     <= w_busy_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_credit_nxt   = r_credit;
      w_phase_nxt    = r_phase;
      w_vend_a_nxt   = 1'b0;
      w_vend_b_nxt   = 1'b0;
      w_change_nxt   = 1'b0;
      w_reject_nxt   = 1'b0;
      w_no_funds_nxt = 1'b0;
      w_price        = w_evt[3] ? c_price_a : c_price_b;
      w_coin         = w_evt[1] ? 5'(c_coin5_val) : 5'(c_coin1_val);
      // 5-bit sum so 14+5 shows up as overflow instead of wrapping
      w_sum          = {1'b0, r_credit} + w_coin;

      case (r_state)
         S_IDLE, S_CREDIT: begin
            if (w_evt[4]) begin
               if (r_state == S_CREDIT) begin
                  w_state_nxt = S_REFUND;
                  w_phase_nxt = 1'b0;
               end
            end else if (w_evt[3] || w_evt[2]) begin
               if (r_state == S_CREDIT && r_credit >= w_price) begin
                  w_state_nxt  = S_VEND;
                  w_credit_nxt = r_credit - w_price;
                  w_vend_a_nxt = w_evt[3];
                  w_vend_b_nxt = ~w_evt[3];
               end else begin
                  w_no_funds_nxt = 1'b1;
               end
            end else if (w_evt[1] || w_evt[0]) begin
               if (w_sum <= c_max) begin
                  w_credit_nxt = w_sum[3:0];
                  w_state_nxt  = S_CREDIT;
               end else begin
                  w_reject_nxt = 1'b1;
               end
            end
         end
         S_VEND: begin
            w_phase_nxt = 1'b0;
            w_state_nxt = (r_credit != 4'd0) ? S_REFUND : S_IDLE;
         end
         S_REFUND: begin
            // r_phase=0: emit a coin this cycle; r_phase=1: gap cycle
            if (!r_phase) begin
               if (r_credit != 4'd0) begin
                  w_change_nxt = 1'b1;
                  w_credit_nxt = r_credit - 4'd1;
                  w_phase_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_phase_nxt = 1'b0;
               if (r_credit == 4'd0) w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      w_busy_nxt = (w_state_nxt == S_VEND) || (w_state_nxt == S_REFUND);
   end

   assign credit       = r_credit;
   assign vend_a       = r_vend_a;
   assign vend_b       = r_vend_b;
   assign change_pulse = r_change;
   assign coin_reject  = r_reject;
   assign no_funds     = r_no_funds;
   assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_coin_vend_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_coin_vend_fsm : directed self-checking bench for coin_vend_fsm    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_coin_vend_fsm;

   logic       vend_clk = 1'b0;
   logic       vend_rst = 1'b1;
   logic [4:0] keys_n   = 5'b11111;   // [4]cancel [3]sel_a [2]sel_b [1]coin5 [0]coin1
   logic [3:0] credit;
   logic       vend_a, vend_b, change_pulse, coin_reject, no_funds, busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [3:0] s_credit;
   logic       s_vend_a, s_vend_b, s_change, s_reject, s_no_funds, s_busy;

   localparam logic [4:0] K_COIN1  = 5'b00001;
   localparam logic [4:0] K_COIN5  = 5'b00010;
   localparam logic [4:0] K_SEL_B  = 5'b00100;
   localparam logic [4:0] K_SEL_A  = 5'b01000;
   localparam logic [4:0] K_CANCEL = 5'b10000;

   coin_vend_fsm dut (
      .vend_clk     (vend_clk),
      .vend_rst     (vend_rst),
      .key_coin1_n  (keys_n[0]),
      .key_coin5_n  (keys_n[1]),
      .key_sel_a_n  (keys_n[3]),
      .key_sel_b_n  (keys_n[2]),
      .key_cancel_n (keys_n[4]),
      .credit       (credit),
      .vend_a       (vend_a),
      .vend_b       (vend_b),
      .change_pulse (change_pulse),
      .coin_reject  (coin_reject),
      .no_funds     (no_funds),
      .busy         (busy)
   );

   always #5 vend_clk = ~vend_clk;

   task automatic tick();
      @(posedge vend_clk);
      #1;
   endtask

   task automatic do_reset();
      keys_n   = 5'b11111;
      vend_rst = 1'b1;
      tick();
      tick();
      vend_rst = 1'b0;
   endtask

   // press keys for one cycle, snapshot outputs of the acting edge, release
   task automatic press(input logic [4:0] mask);
      keys_n = ~mask;
      tick();
      s_credit   = credit;
      s_vend_a   = vend_a;
      s_vend_b   = vend_b;
      s_change   = change_pulse;
      s_reject   = coin_reject;
      s_no_funds = no_funds;
      s_busy     = busy;
      keys_n = 5'b11111;
      tick();
   endtask

   task automatic watch(input int cycles, output int n_chg, output int n_va,
                        output int n_vb, output int n_consec);
      logic prev;
      prev = 1'b0;
      n_chg = 0; n_va = 0; n_vb = 0; n_consec = 0;
      for (int i = 0; i < cycles; i++) begin
         if (change_pulse) begin
            n_chg++;
            if (prev) n_consec++;
         end
         prev = change_pulse;
         if (vend_a) n_va++;
         if (vend_b) n_vb++;
         tick();
      end
   endtask

   task automatic test_reset();
      vend_rst = 1'b1;
      keys_n   = 5'b11111;
      tick();
      tick();
      n_tests++;
      if ({credit, vend_a, vend_b, change_pulse, coin_reject, no_funds, busy} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got credit=%0d va=%b vb=%b chg=%b rej=%b nf=%b busy=%b, expected all 0",
                  credit, vend_a, vend_b, change_pulse, coin_reject, no_funds, busy);
      end
      vend_rst = 1'b0;
      tick();
      n_tests++;
      if (credit !== 4'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got credit=%0d busy=%b, expected 0/0", credit, busy);
      end
   endtask

   task automatic test_buy_a_with_change();
      int nc, nva, nvb, ncons;
      do_reset();
      press(K_COIN5);
      n_tests++;
      if (s_credit !== 4'd5) begin
         n_fail++; $display("FAIL buy_a_coin5: got credit=%0d expected 5", s_credit);
      end
      press(K_COIN1);
      n_tests++;
      if (s_credit !== 4'd6) begin
         n_fail++; $display("FAIL buy_a_coin1: got credit=%0d expected 6", s_credit);
      end
      press(K_SEL_A);
      n_tests++;
      if (s_vend_a !== 1'b1 || s_vend_b !== 1'b0 || s_credit !== 4'd3 || s_busy !== 1'b1) begin
         n_fail++;
         $display("FAIL buy_a_vend: got va=%b vb=%b credit=%0d busy=%b expected 1/0/3/1",
                  s_vend_a, s_vend_b, s_credit, s_busy);
      end
      watch(20, nc, nva, nvb, ncons);
      n_tests++;
      if (nc != 3 || nva != 0 || ncons != 0) begin
         n_fail++;
         $display("FAIL buy_a_change: got changes=%0d extra_vend_a=%0d back_to_back=%0d expected 3/0/0",
                  nc, nva, ncons);
      end
      n_tests++;
      if (credit !== 4'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL buy_a_idle: got credit=%0d busy=%b expected 0/0", credit, busy);
      end
   endtask

   task automatic test_coin_overflow();
      do_reset();
      press(K_COIN5);
      press(K_COIN5);
      press(K_COIN5);
      n_tests++;
      if (s_credit !== 4'd15) begin
         n_fail++; $display("FAIL ovf_full: got credit=%0d expected 15", s_credit);
      end
      press(K_COIN1);
      n_tests++;
      if (s_reject !== 1'b1 || s_credit !== 4'd15) begin
         n_fail++; $display("FAIL ovf_reject: got rej=%b credit=%0d expected 1/15", s_reject, s_credit);
      end
      n_tests++;
      if (coin_reject !== 1'b0 || credit !== 4'd15) begin
         n_fail++; $display("FAIL ovf_pulse_width: got rej=%b credit=%0d expected 0/15", coin_reject, credit);
      end
      do_reset();
      press(K_COIN5);
      press(K_COIN5);
      for (int i = 0; i < 4; i++) press(K_COIN1);
      press(K_COIN5);
      n_tests++;
      if (s_reject !== 1'b1 || s_credit !== 4'd14) begin
         n_fail++; $display("FAIL ovf_14p5: got rej=%b credit=%0d expected 1/14", s_reject, s_credit);
      end
   endtask

   task automatic test_no_funds();
      do_reset();
      press(K_SEL_A);
      n_tests++;
      if (s_no_funds !== 1'b1 || s_credit !== 4'd0 || s_busy !== 1'b0 || s_vend_a !== 1'b0) begin
         n_fail++; $display("FAIL nf_idle: got nf=%b credit=%0d busy=%b va=%b expected 1/0/0/0",
                            s_no_funds, s_credit, s_busy, s_vend_a);
      end
      press(K_COIN1);
      press(K_COIN1);
      press(K_SEL_B);
      n_tests++;
      if (s_no_funds !== 1'b1 || s_credit !== 4'd2 || s_busy !== 1'b0 || s_vend_b !== 1'b0) begin
         n_fail++; $display("FAIL nf_credit: got nf=%b credit=%0d busy=%b vb=%b expected 1/2/0/0",
                            s_no_funds, s_credit, s_busy, s_vend_b);
      end
      n_tests++;
      if (no_funds !== 1'b0 || credit !== 4'd2) begin
         n_fail++; $display("FAIL nf_after: got nf=%b credit=%0d expected 0/2", no_funds, credit);
      end
   endtask

   task automatic test_cancel_priority();
      int nc, nva, nvb, ncons;
      do_reset();
      for (int i = 0; i < 4; i++) press(K_COIN1);
      press(K_CANCEL | K_SEL_A);
      n_tests++;
      if (s_vend_a !== 1'b0 || s_busy !== 1'b1 || s_credit !== 4'd4) begin
         n_fail++; $display("FAIL cancel_win: got va=%b busy=%b credit=%0d expected 0/1/4",
                            s_vend_a, s_busy, s_credit);
      end
      watch(20, nc, nva, nvb, ncons);
      n_tests++;
      if (nc != 4 || nva != 0 || ncons != 0 || credit !== 4'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL cancel_refund: got changes=%0d va=%0d b2b=%0d credit=%0d busy=%b expected 4/0/0/0/0",
                            nc, nva, ncons, credit, busy);
      end
   endtask

   task automatic test_held_key();
      int nc, nva, nvb, ncons;
      do_reset();
      keys_n[0] = 1'b0;
      for (int i = 0; i < 100; i++) tick();
      n_tests++;
      if (credit !== 4'd1) begin
         n_fail++; $display("FAIL held_single: got credit=%0d expected 1", credit);
      end
      keys_n = 5'b11111;
      tick();
      press(K_COIN5);
      press(K_CANCEL);
      keys_n[0] = 1'b0;
      watch(30, nc, nva, nvb, ncons);
      n_tests++;
      if (nc != 6 || credit !== 4'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL held_refund_ignore: got changes=%0d credit=%0d busy=%b expected 6/0/0",
                            nc, credit, busy);
      end
      keys_n = 5'b11111;
      tick();
      tick();
      n_tests++;
      if (credit !== 4'd0) begin
         n_fail++; $display("FAIL held_not_queued: got credit=%0d expected 0", credit);
      end
   endtask

   task automatic test_reset_mid_refund();
      int nc, nva, nvb, ncons;
      do_reset();
      press(K_COIN5);
      press(K_CANCEL);
      tick();
      tick();
      n_tests++;
      if (change_pulse !== 1'b1 || credit !== 4'd3) begin
         n_fail++; $display("FAIL rst_mid_2nd_pulse: got chg=%b credit=%0d expected 1/3", change_pulse, credit);
      end
      vend_rst = 1'b1;
      tick();
      n_tests++;
      if (credit !== 4'd0 || busy !== 1'b0 || change_pulse !== 1'b0) begin
         n_fail++; $display("FAIL rst_mid_state: got credit=%0d busy=%b chg=%b expected 0/0/0",
                            credit, busy, change_pulse);
      end
      vend_rst = 1'b0;
      watch(20, nc, nva, nvb, ncons);
      n_tests++;
      if (nc != 0 || nva != 0 || nvb != 0 || credit !== 4'd0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL rst_no_more: got changes=%0d va=%0d vb=%0d credit=%0d busy=%b expected 0/0/0/0/0",
                            nc, nva, nvb, credit, busy);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      press(K_COIN5);
      press(K_SEL_B);
      n_tests++;
      if (s_vend_b !== 1'b1 || s_vend_a !== 1'b0 || s_credit !== 4'd0 || s_busy !== 1'b1) begin
         n_fail++; $display("FAIL b2b_vend_b: got vb=%b va=%b credit=%0d busy=%b expected 1/0/0/1",
                            s_vend_b, s_vend_a, s_credit, s_busy);
      end
      n_tests++;
      if (busy !== 1'b0 || vend_b !== 1'b0 || change_pulse !== 1'b0) begin
         n_fail++; $display("FAIL b2b_exact_idle: got busy=%b vb=%b chg=%b expected 0/0/0",
                            busy, vend_b, change_pulse);
      end
      press(K_COIN1);
      n_tests++;
      if (s_credit !== 4'd1 || s_reject !== 1'b0) begin
         n_fail++; $display("FAIL b2b_next_coin: got credit=%0d rej=%b expected 1/0", s_credit, s_reject);
      end
      press(K_SEL_B | K_COIN5);
      n_tests++;
      if (s_no_funds !== 1'b1 || s_credit !== 4'd1) begin
         n_fail++; $display("FAIL b2b_sel_over_coin: got nf=%b credit=%0d expected 1/1", s_no_funds, s_credit);
      end
   endtask

   initial begin
      test_reset();
      test_buy_a_with_change();
      test_coin_overflow();
      test_no_funds();
      test_cancel_priority();
      test_held_key();
      test_reset_mid_refund();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
